// File: rtl/run_detect_sched.sv
// run_detect_sched: round-robin scheduler sharing one serial run-of-ones
// detector among NREQ bit-stream requesters. One requester owns the engine
// per frame; a one-cycle DONE state reports the frame's hit count and ID.

module run_detect_sched #(
    parameter int NREQ    = 4,
    parameter int RUN_LEN = 3,
    parameter int CNT_W   = 8,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  bit_in,
    input  logic [NREQ-1:0]  bit_valid,
    input  logic [NREQ-1:0]  bit_last,
    output logic [NREQ-1:0]  gnt,
    output logic             busy,
    output logic             z,
    output logic             done,
    output logic [IDW-1:0]   done_id,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             aborted
);

    localparam int RW = $clog2(RUN_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t           r_state;
    logic [NREQ-1:0]  r_gnt;
    logic [IDW-1:0]   r_sel;
    logic [IDW-1:0]   r_ptr;
    logic [RW-1:0]    r_run;
    logic [CNT_W-1:0] r_hits;
    logic             r_done;
    logic [IDW-1:0]   r_doneId;
    logic [CNT_W-1:0] r_hitOut;
    logic             r_aborted;

    logic             w_found;
    logic [IDW-1:0]   w_winner;
    logic [IDW-1:0]   w_cand;
    logic [IDW-1:0]   w_ptrNext;
    logic             w_selValid;
    logic             w_selBit;
    logic             w_selLast;
    logic             w_selReq;
    logic             w_endFrame;
    logic             w_abort;
    logic             w_z;
    logic [RW-1:0]    w_runNext;
    logic [CNT_W-1:0] w_hitNext;

    // Round-robin search: walk downward so the lowest offset from ptr wins last.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_cand = IDW'((int'(r_ptr) + i) % NREQ);
            if (req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
        w_ptrNext = IDW'((int'(w_winner) + 1) % NREQ);
    end

    // Detector datapath for the granted channel: hit output, next run and hit counts.
    always_comb begin
        w_selValid = bit_valid[r_sel];
        w_selBit   = bit_in[r_sel];
        w_selLast  = bit_last[r_sel];
        w_selReq   = req[r_sel];
        w_endFrame = w_selValid & w_selLast;
        w_abort    = ~w_selReq & ~w_endFrame;
        w_z        = (r_state == STREAM) & w_selValid & w_selBit &
                     (r_run == RW'(RUN_LEN));
        w_runNext  = r_run;
        if (w_selValid) begin
            if (!w_selBit) begin
                w_runNext = '0;
            end else if (r_run != RW'(RUN_LEN)) begin
                w_runNext = r_run + 1'b1;
            end
        end
        w_hitNext = r_hits;
        if (w_z && (r_hits != '1)) begin
            w_hitNext = r_hits + 1'b1;
        end
    end

    // Frame FSM: arbitration in IDLE/DONE, streaming, and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_sel     <= '0;
            r_ptr     <= '0;
            r_run     <= '0;
            r_hits    <= '0;
            r_done    <= 1'b0;
            r_doneId  <= '0;
            r_hitOut  <= '0;
            r_aborted <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    r_gnt <= '0;
                    if (w_found) begin
                        r_gnt   <= NREQ'(1) << w_winner;
                        r_sel   <= w_winner;
                        r_ptr   <= w_ptrNext;
                        r_run   <= '0;
                        r_hits  <= '0;
                        r_state <= STREAM;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                STREAM: begin
                    if (w_abort) begin
                        r_state   <= DONE;
                        r_gnt     <= '0;
                        r_done    <= 1'b1;
                        r_doneId  <= r_sel;
                        r_hitOut  <= r_hits;
                        r_aborted <= 1'b1;
                    end else begin
                        r_run  <= w_runNext;
                        r_hits <= w_hitNext;
                        if (w_endFrame) begin
                            r_state   <= DONE;
                            r_gnt     <= '0;
                            r_done    <= 1'b1;
                            r_doneId  <= r_sel;
                            r_hitOut  <= w_hitNext;
                            r_aborted <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign busy    = |r_gnt;
    assign z       = w_z;
    assign done    = r_done;
    assign done_id = r_doneId;
    assign hit_cnt = r_hitOut;
    assign aborted = r_aborted;

endmodule

// File: tb/tb_run_detect_sched.sv
// tb_run_detect_sched: scoreboard bench for run_detect_sched. A second
// instance with a 3-bit hit counter shares all inputs to exercise saturation.

module tb_run_detect_sched;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] bit_in;
    logic [3:0] bit_valid;
    logic [3:0] bit_last;

    logic [3:0] gnt;
    logic       busy;
    logic       z;
    logic       done;
    logic [1:0] done_id;
    logic [7:0] hit_cnt;
    logic       aborted;

    logic [3:0] gnt2;
    logic       busy2;
    logic       z2;
    logic       done2;
    logic [1:0] done_id2;
    logic [2:0] hit_cnt2;
    logic       aborted2;

    typedef struct {
        int id;
        int hits;
        int hits2;
        bit ab;
    } exp_t;

    exp_t expQ[$];
    int   errCount   = 0;
    int   checkCount = 0;

    run_detect_sched #(.NREQ(4), .RUN_LEN(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .bit_in(bit_in),
        .bit_valid(bit_valid), .bit_last(bit_last), .gnt(gnt), .busy(busy),
        .z(z), .done(done), .done_id(done_id), .hit_cnt(hit_cnt),
        .aborted(aborted)
    );

    run_detect_sched #(.NREQ(4), .RUN_LEN(3), .CNT_W(3)) dutSmall (
        .clk(clk), .rst(rst), .req(req), .bit_in(bit_in),
        .bit_valid(bit_valid), .bit_last(bit_last), .gnt(gnt2), .busy(busy2),
        .z(z2), .done(done2), .done_id(done_id2), .hit_cnt(hit_cnt2),
        .aborted(aborted2)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic clearBits();
        bit_in    = '0;
        bit_valid = '0;
        bit_last  = '0;
    endtask

    // Drive one frame on requester r; pattern bit k is sent in stream cycle k.
    // With abortIt the final bit is presented while req drops (it must be ignored).
    task automatic applyStimulus(input int r, input logic [31:0] pat, input int n,
                                 input bit abortIt, input bit noise);
        int   run   = 0;
        int   hits  = 0;
        int   hits2 = 0;
        bit   expZ;
        exp_t e;
        @(negedge clk);
        clearBits();
        req = 4'(1 << r);
        @(negedge clk);
        checkOutput("grant", gnt, 32'(1 << r));
        checkOutput("busyGranted", busy, 1);
        for (int k = 0; k < n; k++) begin
            if (noise) begin
                bit_in    = ~(4'(1 << r));
                bit_valid = ~(4'(1 << r));
                bit_last  = ~(4'(1 << r));
            end
            bit_valid[r] = 1'b1;
            bit_in[r]    = pat[k];
            bit_last[r]  = (k == n - 1) && !abortIt;
            if (abortIt && k == n - 1) req[r] = 1'b0;
            expZ = pat[k] && (run == 3);
            #1;
            checkOutput($sformatf("z[r%0d b%0d]", r, k), z, expZ);
            if (!(abortIt && k == n - 1)) begin
                if (expZ) begin
                    if (hits < 255) hits++;
                    if (hits2 < 7) hits2++;
                end
                if (!pat[k]) run = 0;
                else if (run < 3) run++;
            end
            @(negedge clk);
        end
        e.id = r; e.hits = hits; e.hits2 = hits2; e.ab = abortIt;
        expQ.push_back(e);
        req = '0;
        clearBits();
        #1;
        checkOutput("donePulse", done, 1);
        checkOutput("gntInDone", gnt, 0);
        checkOutput("busyInDone", busy, 0);
        @(negedge clk);
    endtask

    // Scoreboard and grant invariants, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        checkOutput("gntOneHot", $onehot0(gnt), 1);
        if (done) begin
            if (expQ.size() == 0) begin
                checkOutput("doneUnexpected", done, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("doneId", done_id, e.id);
                checkOutput("hitCnt", hit_cnt, e.hits);
                checkOutput("hitCntSmall", hit_cnt2, e.hits2);
                checkOutput("aborted", aborted, e.ab);
            end
        end
    end

    initial begin
        int   expOrder[4] = '{0, 2, 0, 2};
        int   nGrant = 0;
        int   cur    = -1;
        int   bitNo  = 0;
        int   idx;
        bit   sawDone = 0;
        exp_t e;

        rst = 1'b1;
        req = '0;
        clearBits();
        repeat (2) @(negedge clk);
        checkOutput("rstGnt", gnt, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstDoneId", done_id, 0);
        checkOutput("rstHitCnt", hit_cnt, 0);
        checkOutput("rstAborted", aborted, 0);
        checkOutput("rstZ", z, 0);
        rst = 1'b0;
        @(negedge clk);

        // Round robin: requesters 0 and 2 keep requesting, 2-bit frames
        req = 4'b0101;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            clearBits();
            if (sawDone && nGrant < 4) checkOutput("rrGntAfterDone", busy, 1);
            sawDone = done;
            if (cur < 0 && gnt != 0) begin
                idx = 0;
                for (int j = 0; j < 4; j++) if (gnt[j]) idx = j;
                if (nGrant < 4) begin
                    checkOutput($sformatf("rrOrder%0d", nGrant), idx, expOrder[nGrant]);
                    e.id = idx; e.hits = 0; e.hits2 = 0; e.ab = 0;
                    expQ.push_back(e);
                    nGrant++;
                end
                cur   = idx;
                bitNo = 0;
            end
            if (cur >= 0) begin
                bit_valid[cur] = 1'b1;
                bit_last[cur]  = (bitNo == 1);
                bitNo++;
                if (bitNo == 2) begin
                    cur = -1;
                    if (nGrant == 4) req = '0;
                end
            end
        end
        checkOutput("rrGrantCount", nGrant, 4);
        clearBits();
        repeat (2) @(negedge clk);

        // Single frame on requester 1: 1,1,1,1,0,1,1,1,1,0
        applyStimulus(1, 32'b0111101111, 10, 0, 0);
        // Saturation: 12 ones ending in last (9 hits, small counter stops at 7)
        applyStimulus(2, 32'hFFF, 12, 0, 0);
        // Abort after 5 ones on requester 3, then a fresh frame starts from run 0
        applyStimulus(3, 32'b11111, 5, 1, 0);
        applyStimulus(3, 32'b0111, 4, 0, 0);
        // Isolation: all-zero frame on 0 with ones on every other channel
        applyStimulus(0, 32'h0, 6, 0, 1);

        // Mid-frame reset
        @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        checkOutput("preRstGnt", gnt, 1);
        for (int k = 0; k < 3; k++) begin
            bit_valid[0] = 1'b1;
            bit_in[0]    = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1;
        req = '0;
        clearBits();
        @(negedge clk);
        checkOutput("midRstGnt", gnt, 0);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstDone", done, 0);
        checkOutput("midRstDoneId", done_id, 0);
        checkOutput("midRstHitCnt", hit_cnt, 0);
        checkOutput("midRstAborted", aborted, 0);
        checkOutput("midRstZ", z, 0);
        rst = 1'b0;
        req = 4'b0011;
        @(negedge clk);
        checkOutput("postRstGnt", gnt, 1);
        e.id = 0; e.hits = 0; e.hits2 = 0; e.ab = 1;
        expQ.push_back(e);
        req = '0;
        @(negedge clk);
        checkOutput("postRstAbortDone", done, 1);
        repeat (3) @(negedge clk);

        checkOutput("scoreboardEmpty", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
